// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: synchronizes RX_IN, majority-votes each bit,
// deserializes 8 data bits LSB-first and checks start/parity/stop bits.
module uart_rx_frame_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PRESC_W = 6,
  parameter int unsigned EDGE_W  = 5
) (
  input  logic               clk,
  input  logic               ARSTn,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic [EDGE_W-1:0]  edge_cnt,
  input  logic [3:0]         bit_cnt,
  output logic               cnt_en,
  output logic               busy,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               strt_glitch
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, rx_s_q;
  logic [2:0]          samp_q;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   p_data_q, p_data_d;
  logic                perr_q, perr_d;
  logic                cnt_en_q, cnt_en_d;
  logic                dv_q, dv_d;
  logic                par_err_q, par_err_d;
  logic                stp_err_q, stp_err_d;
  logic                glitch_q, glitch_d;

  logic [PRESC_W-1:0]  edge_ext;
  logic [PRESC_W-1:0]  half;
  logic                sampled_bit;
  logic                bit_end;

  assign edge_ext    = PRESC_W'(edge_cnt);
  assign half        = Prescale >> 1;
  assign sampled_bit = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                       (samp_q[1] & samp_q[2]);
  assign bit_end     = cnt_en_q & (edge_ext == (Prescale - PRESC_W'(1)));

  // Two-flop synchronizer, idles high like the line
  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      rx_s_q  <= sync1_q;
    end
  end

  // Three samples straddling the bit centre for the majority vote
  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      samp_q <= 3'b000;
    end else if (cnt_en_q) begin
      if (edge_ext == (half - PRESC_W'(1))) samp_q[0] <= rx_s_q;
      if (edge_ext == half)                 samp_q[1] <= rx_s_q;
      if (edge_ext == (half + PRESC_W'(1))) samp_q[2] <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      p_data_q  <= '0;
      perr_q    <= 1'b0;
      cnt_en_q  <= 1'b0;
      dv_q      <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      glitch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      p_data_q  <= p_data_d;
      perr_q    <= perr_d;
      cnt_en_q  <= cnt_en_d;
      dv_q      <= dv_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      glitch_q  <= glitch_d;
    end
  end

  // Frame sequencing; every decision is taken on the last edge of a bit
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    p_data_d  = p_data_q;
    perr_d    = perr_q;
    dv_d      = 1'b0;
    par_err_d = 1'b0;
    stp_err_d = 1'b0;
    glitch_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (bit_end) begin
          if (sampled_bit) begin
            glitch_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {sampled_bit, shift_q[DATA_W-1:1]};
          if (bit_cnt == 4'(DATA_W)) state_d = PAR_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          if (sampled_bit != ((^shift_q) ^ PAR_TYP)) begin
            perr_d    = 1'b1;
            par_err_d = 1'b1;
          end
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!sampled_bit) begin
            stp_err_d = 1'b1;
          end else if (!perr_q) begin
            p_data_d = shift_q;
            dv_d     = 1'b1;
          end
          perr_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cnt_en_d = (state_d != IDLE);
  end

  assign cnt_en      = cnt_en_q;
  assign busy        = cnt_en_q;
  assign P_DATA      = p_data_q;
  assign data_valid  = dv_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign strt_glitch = glitch_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; includes a behavioural edge/bit
// counter so the controller runs closed-loop.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       ARSTn;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       cnt_en;
  logic       busy;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       strt_glitch;

  int checks   = 0;
  int failures = 0;
  int n_dv, n_par, n_stp, n_gl;
  logic [7:0] dv_vals[$];

  uart_rx_frame_ctrl dut (
    .clk        (clk),
    .ARSTn      (ARSTn),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .cnt_en     (cnt_en),
    .busy       (busy),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .strt_glitch(strt_glitch)
  );

  always #5 clk = ~clk;

  // Edge/bit counter the controller drives through cnt_en
  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      edge_cnt <= 5'd0;
      bit_cnt  <= 4'd0;
    end else if (!cnt_en) begin
      edge_cnt <= 5'd0;
      bit_cnt  <= 4'd0;
    end else if ({1'b0, edge_cnt} == (Prescale - 6'd1)) begin
      edge_cnt <= 5'd0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 5'd1;
    end
  end

  // Count strobe cycles so a multi-cycle pulse shows up as a count > 1
  always @(negedge clk) begin
    if (ARSTn) begin
      if (data_valid) begin
        n_dv = n_dv + 1;
        dv_vals.push_back(P_DATA);
      end
      if (par_err)     n_par = n_par + 1;
      if (stp_err)     n_stp = n_stp + 1;
      if (strt_glitch) n_gl  = n_gl + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_dv = 0; n_par = 0; n_stp = 0; n_gl = 0;
    dv_vals.delete();
  endtask

  task automatic send_bit(input logic v, input int gpos);
    for (int i = 0; i < int'(Prescale); i++) begin
      RX_IN = (i == gpos) ? ~v : v;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit,
                            input logic stop_bit, input int gbit, input int gpos);
    send_bit(1'b0, -1);
    check("busy_mid_frame", 32'(busy), 32'd1);
    for (int b = 0; b < 8; b++) send_bit(d[b], (b == gbit) ? gpos : -1);
    if (PAR_EN) send_bit(par_bit, -1);
    send_bit(stop_bit, -1);
    RX_IN = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag, input int dv, input int pe,
                              input int se, input int gl);
    check({tag, "_dv"},  32'(n_dv),  32'(dv));
    check({tag, "_par"}, 32'(n_par), 32'(pe));
    check({tag, "_stp"}, 32'(n_stp), 32'(se));
    check({tag, "_gl"},  32'(n_gl),  32'(gl));
  endtask

  initial begin
    clear_counts();
    ARSTn    = 1'b0;
    RX_IN    = 1'b1;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    #12;
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_pdata",  32'(P_DATA), 32'h00);
    check("rst_strobes", 32'({data_valid, par_err, stp_err, strt_glitch}), 32'd0);
    ARSTn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 0xA5, Prescale 8, no parity
    clear_counts();
    send_frame(8'hA5, 1'b0, 1'b1, -1, -1);
    wait_idle(100);
    check_counts("a5", 1, 0, 0, 0);
    check("a5_pdata", 32'(P_DATA), 32'hA5);

    // 0x3C, Prescale 16, even parity, correct then wrong parity bit
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    clear_counts();
    send_frame(8'h3C, 1'b0, 1'b1, -1, -1);
    wait_idle(100);
    check_counts("3c_good", 1, 0, 0, 0);
    check("3c_good_pdata", 32'(P_DATA), 32'h3C);
    clear_counts();
    send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
    wait_idle(100);
    check_counts("3c_bad", 0, 1, 0, 0);
    check("3c_bad_pdata", 32'(P_DATA), 32'h3C);

    // 0x81, Prescale 32, odd parity correct, stop bit forced low
    Prescale = 6'd32; PAR_TYP = 1'b1;
    clear_counts();
    send_frame(8'h81, 1'b1, 1'b0, -1, -1);
    wait_idle(200);
    check_counts("81_stp", 0, 0, 1, 0);
    check("81_pdata", 32'(P_DATA), 32'h3C);

    // Short low pulse rejected as false start
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_counts();
    RX_IN = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("glitch_busy", 32'(busy), 32'd1);
    RX_IN = 1'b1;
    wait_idle(100);
    check_counts("glitch", 0, 0, 0, 1);
    check("glitch_cnt_en", 32'(cnt_en), 32'd0);

    // 0xFF with a one-clock low spike on the centre sample of data bit 3
    Prescale = 6'd8;
    clear_counts();
    send_frame(8'hFF, 1'b0, 1'b1, 3, 5);
    wait_idle(100);
    check_counts("ff_vote", 1, 0, 0, 0);
    check("ff_pdata", 32'(P_DATA), 32'hFF);

    // Back-to-back frames with no idle gap
    clear_counts();
    send_frame(8'h11, 1'b0, 1'b1, -1, -1);
    send_frame(8'hEE, 1'b0, 1'b1, -1, -1);
    wait_idle(100);
    check_counts("b2b", 2, 0, 0, 0);
    if (dv_vals.size() == 2) begin
      check("b2b_first",  32'(dv_vals[0]), 32'h11);
      check("b2b_second", 32'(dv_vals[1]), 32'hEE);
    end else begin
      check("b2b_nvals", 32'(dv_vals.size()), 32'd2);
    end
    check("b2b_pdata", 32'(P_DATA), 32'hEE);

    // Reset asserted in the middle of a third frame's data bits
    clear_counts();
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2;
    ARSTn = 1'b0;
    #1;
    check("abort_cnt_en",  32'(cnt_en), 32'd0);
    check("abort_busy",    32'(busy),   32'd0);
    check("abort_pdata",   32'(P_DATA), 32'h00);
    check("abort_strobes", 32'({data_valid, par_err, stp_err, strt_glitch}), 32'd0);
    RX_IN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ARSTn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_counts("abort_after", 0, 0, 0, 0);
    check("abort_after_busy",  32'(busy),   32'd0);
    check("abort_after_pdata", 32'(P_DATA), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
UART receive frame controller that sits directly downstream of the RX edge/bit counter and closes the loop with it. It drives the counter's enable and consumes its edge_cnt and bit_cnt outputs. It also oversamples RX_IN with a 3-point majority vote, deserializes 8 data bits LSB-first, and checks the start, parity and stop bits. Each good byte is presented as P_DATA with a single-cycle data_valid strobe to the RX-side sync/FIFO logic.

Parameters:
DATA_W, 8, data bits per frame (only 8 supported; bit_cnt encoding depends on it)
PRESC_W, 6, width of Prescale input
EDGE_W, 5, width of edge_cnt input

Ports:
clk  input  1  oversampling clock (Prescale x baud)
ARSTn  input  1  asynchronous reset, active-low
RX_IN  input  1  asynchronous serial line, idle high
Prescale  input  6  oversampling ratio; legal values 8, 16, 32
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
edge_cnt  input  5  from edge counter; 0..Prescale-1 within a bit
bit_cnt  input  4  from edge counter; 0 = start, 1..8 = data, 9 = parity or stop, 10 = stop (PAR_EN=1)
cnt_en  output  1  enable to edge counter; counter clears while low
busy  output  1  high while a frame is in progress (state != IDLE)
P_DATA  output  8  last good received byte
data_valid  output  1  one-cycle strobe, P_DATA updated this cycle
par_err  output  1  one-cycle strobe, parity mismatch
stp_err  output  1  one-cycle strobe, stop bit sampled 0
strt_glitch  output  1  one-cycle strobe, start bit sampled 1

Behaviour:
- Reset: all outputs 0, P_DATA=0x00, state IDLE, synchronizer flops 1, sample regs 0, shift reg 0.
- RX_IN passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized rx_s (2-cycle latency).
- Sampler registers rx_s at edge_cnt == Prescale/2-1, Prescale/2, Prescale/2+1 while cnt_en=1. sampled_bit = majority(s0,s1,s2).
- "bit_end" is defined as cnt_en & (edge_cnt == Prescale-1). All frame decisions are taken at bit_end.
- cnt_en is registered: 1 in START/DATA/PARITY/STOP, 0 in IDLE. busy equals cnt_en.
- IDLE: when rx_s==0, go to START. The counter therefore sees edge_cnt=0 on the first START cycle.
- START: at bit_end, if sampled_bit==1, pulse strt_glitch and go to IDLE. Otherwise go to DATA.
- DATA: at bit_end, shift_reg <= {sampled_bit, shift_reg[7:1]} and compute running parity. At bit_end with bit_cnt==8, go to PARITY if PAR_EN else STOP.
- PARITY: at bit_end, expected = ^shift_reg ^ PAR_TYP. Mismatch sets an internal perr flag and pulses par_err. Then go to STOP.
- STOP: at bit_end, if sampled_bit==0, pulse stp_err. If sampled_bit==1 and perr==0, P_DATA <= shift_reg and pulse data_valid. In all cases go to IDLE and clear perr.
- On a bad frame P_DATA holds its previous value. At most one of data_valid, stp_err, strt_glitch pulses per frame. par_err can precede stp_err in the same frame.
- Back-to-back frames: a start edge that is present when the FSM re-enters IDLE is detected on the next cycle. Worst-case added skew is 1 clk per frame.
- PAR_EN, PAR_TYP and Prescale must be static while busy=1; behaviour is undefined if they change mid-frame.
- An ARSTn assertion mid-frame aborts the frame: no strobes, cnt_en drops immediately, and P_DATA is cleared.
- Prescale values other than 8/16/32 are out of scope; no checking is performed.
- The counter wrapping bit_cnt to 0 at the frame end coincides with the FSM returning to IDLE. The FSM never relies on bit_cnt==0 after START.

Test Plan:
- Prescale=8, PAR_EN=0, send 0xA5 (1 start, 8 data, 1 stop) -> data_valid pulses once at end of stop bit; P_DATA=0xA5; no error strobes; busy low 1 cycle later.
- Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 -> P_DATA=0x3C, data_valid=1. Repeat with parity bit 1 -> par_err pulse, no data_valid, P_DATA stays 0x3C.
- Prescale=32, PAR_EN=1, PAR_TYP=1, send 0x81 with stop bit forced 0 -> stp_err pulse, no data_valid, P_DATA unchanged.
- Prescale=16, RX_IN low for 4 clks then high -> strt_glitch pulse at edge_cnt=15 of bit 0; FSM in IDLE; cnt_en=0; no data_valid.
- Prescale=8, single-clk low glitch at sample point Prescale/2 of data bit 3 in 0xFF -> majority vote yields 1; P_DATA=0xFF.
- Prescale=8, two back-to-back frames 0x11 and 0xEE with no idle gap -> two data_valid pulses, values correct. Then assert ARSTn mid-data of a third frame -> all outputs 0, no strobe.
